// File: rtl/bch_frame_ctrl.sv
// Host-side sequencer for the BCH decoder core: load W words, start the core, stream error locations back.
// Latency: set -> first ready 1 cycle; last write -> core_start 1 cycle; accepted beat -> finish 1 cycle.
// Backpressure: core_err_rdy held high only in OUT; optional watchdog enabled by BCH_CTRL_TIMEOUT_EN.
module bch_frame_ctrl #(
  parameter int DATA_W      = 64,
  parameter int LOC_W       = 10,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              set,
  input  logic              mode,
  input  logic [1:0]        code,
  input  logic [DATA_W-1:0] idata,
  output logic              ready,
  output logic              finish,
  output logic [LOC_W-1:0]  odata,
  output logic              core_start,
  output logic              core_mode,
  output logic [1:0]        core_code,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              core_done,
  input  logic [3:0]        core_nerr,
  input  logic              core_err_vld,
  input  logic [LOC_W-1:0]  core_err_loc,
  input  logic              core_err_last,
  output logic              core_err_rdy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_OUT, S_LAST} state_t;

  // All-ones location never names a real bit position, so it flags "no location".
  localparam logic [LOC_W-1:0] SENTINEL = {LOC_W{1'b1}};

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
  logic                start_q, start_d;
  logic                finish_q, finish_d;
  logic [LOC_W-1:0]    odata_q, odata_d;
  logic [ADDR_W-1:0]   rcnt_q, rcnt_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                mode_q, mode_d;
  logic [1:0]          code_q, code_d;
  logic [ADDR_W-1:0]   wlast;
  logic                err_rdy;
  logic                tmo_hit;

  // Index of the final word for the latched frame type (W-1).
  always_comb begin
    wlast = '0;
    case ({mode_q, code_q})
      3'b0_01: wlast = ADDR_W'(0);
      3'b0_10: wlast = ADDR_W'(3);
      3'b0_11: wlast = ADDR_W'(15);
      3'b1_01: wlast = ADDR_W'(7);
      3'b1_10: wlast = ADDR_W'(31);
      3'b1_11: wlast = ADDR_W'(127);
      default: wlast = '0;
    endcase
  end

`ifdef BCH_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Watchdog: held at zero during LOAD so it starts fresh on entry to RUN, counts through RUN and OUT.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_LOAD) tmo_d = '0;
    else if (state_q == S_RUN || state_q == S_OUT) tmo_d = tmo_q + 1'b1;
    tmo_hit = (state_q == S_RUN || state_q == S_OUT) && (tmo_q == TW'(TIMEOUT_CYC - 1));
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    wr_en_d  = 1'b0;
    start_d  = 1'b0;
    finish_d = 1'b0;
    odata_d  = odata_q;
    rcnt_d   = rcnt_q;
    waddr_d  = waddr_q;
    mode_d   = mode_q;
    code_d   = code_q;
    err_rdy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (set && code != 2'd0) begin
          mode_d  = mode;
          code_d  = code;
          rcnt_d  = '0;
          waddr_d = '0;
          ready_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Each ready cycle schedules a capture one cycle later.
        if (ready_q) begin
          wr_en_d = 1'b1;
          if (rcnt_q != wlast) begin
            ready_d = 1'b1;
            rcnt_d  = rcnt_q + 1'b1;
          end
        end
        if (wr_en_q) begin
          if (waddr_q == wlast) begin
            start_d = 1'b1;
            state_d = S_RUN;
          end else begin
            waddr_d = waddr_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (core_done) begin
          if (core_nerr == 4'd0) begin
            finish_d = 1'b1;
            odata_d  = SENTINEL;
            state_d  = S_LAST;
          end else begin
            state_d = S_OUT;
          end
        end else if (tmo_hit) begin
          finish_d = 1'b1;
          odata_d  = SENTINEL;
          state_d  = S_LAST;
        end
      end
      S_OUT: begin
        err_rdy = !tmo_hit;
        if (core_err_vld && err_rdy) begin
          finish_d = 1'b1;
          odata_d  = core_err_loc;
          if (core_err_last) state_d = S_LAST;
        end else if (tmo_hit) begin
          finish_d = 1'b1;
          odata_d  = SENTINEL;
          state_d  = S_LAST;
        end
      end
      S_LAST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      odata_q  <= '0;
      rcnt_q   <= '0;
      waddr_q  <= '0;
      mode_q   <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      wr_en_q  <= wr_en_d;
      start_q  <= start_d;
      finish_q <= finish_d;
      odata_q  <= odata_d;
      rcnt_q   <= rcnt_d;
      waddr_q  <= waddr_d;
      mode_q   <= mode_d;
      code_q   <= code_d;
    end
  end

  assign ready        = ready_q;
  assign finish       = finish_q;
  assign odata        = odata_q;
  assign core_start   = start_q;
  assign core_mode    = mode_q;
  assign core_code    = code_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = waddr_q;
  // Host word passes straight through on the capture cycle; zero otherwise.
  assign wr_data      = wr_en_q ? idata : '0;
  assign core_err_rdy = err_rdy;

endmodule

// File: tb/tb_bch_frame_ctrl.sv
module tb_bch_frame_ctrl;
  localparam int DATA_W = 64;
  localparam int LOC_W  = 10;
  localparam int ADDR_W = 7;
  localparam int TMO    = 100;
  localparam int MAXC   = 8192;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              set = 1'b0;
  logic              mode = 1'b0;
  logic [1:0]        code = 2'd0;
  logic [DATA_W-1:0] idata = '0;
  logic              ready, finish, core_start, core_mode, wr_en, core_err_rdy;
  logic [LOC_W-1:0]  odata;
  logic [1:0]        core_code;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              core_done = 1'b0;
  logic [3:0]        core_nerr = 4'd0;
  logic              core_err_vld = 1'b0;
  logic [LOC_W-1:0]  core_err_loc = '0;
  logic              core_err_last = 1'b0;

  bch_frame_ctrl #(.DATA_W(DATA_W), .LOC_W(LOC_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn), .set(set), .mode(mode), .code(code), .idata(idata),
    .ready(ready), .finish(finish), .odata(odata), .core_start(core_start),
    .core_mode(core_mode), .core_code(core_code), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_done(core_done), .core_nerr(core_nerr),
    .core_err_vld(core_err_vld), .core_err_loc(core_err_loc),
    .core_err_last(core_err_last), .core_err_rdy(core_err_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Expected per-cycle outputs, filled from the frame schedule.
  bit                e_rdy[MAXC];
  bit                e_wr[MAXC];
  bit                e_st[MAXC];
  bit                e_fin[MAXC];
  bit                e_err_rdy[MAXC];
  logic [ADDR_W-1:0] e_addr[MAXC];
  logic [DATA_W-1:0] e_wdat[MAXC];
  logic [LOC_W-1:0]  e_od[MAXC];
  logic              e_cm[MAXC];
  logic [1:0]        e_cc[MAXC];

  int n_ready_seen, n_start_seen;
  int fin_seen[$];
  int wa_seen[$];
  int locs_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the schedule, plus simple observation logs.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      chk("ready", {63'd0, ready}, {63'd0, e_rdy[cyc]});
      chk("wr_en", {63'd0, wr_en}, {63'd0, e_wr[cyc]});
      chk("core_start", {63'd0, core_start}, {63'd0, e_st[cyc]});
      chk("finish", {63'd0, finish}, {63'd0, e_fin[cyc]});
      chk("core_err_rdy", {63'd0, core_err_rdy}, {63'd0, e_err_rdy[cyc]});
      if (e_wr[cyc]) begin
        chk("wr_addr", 64'(wr_addr), 64'(e_addr[cyc]));
        chk("wr_data", wr_data, e_wdat[cyc]);
      end
      if (e_fin[cyc]) chk("odata", 64'(odata), 64'(e_od[cyc]));
      if (e_st[cyc]) begin
        chk("core_mode", 64'(core_mode), 64'(e_cm[cyc]));
        chk("core_code", 64'(core_code), 64'(e_cc[cyc]));
      end
      if (ready) n_ready_seen++;
      if (core_start) n_start_seen++;
      if (finish) fin_seen.push_back(int'(odata));
      if (wr_en) wa_seen.push_back(int'(wr_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_ready_seen = 0;
    n_start_seen = 0;
    fin_seen.delete();
    wa_seen.delete();
  endtask

  function automatic int wcnt(input bit m, input logic [1:0] c);
    int base;
    base = (c == 2'd1) ? 1 : (c == 2'd2) ? 4 : 16;
    return m ? base * 8 : base;
  endfunction

  // Idle cycles: core noise and code-0 set pulses, all of which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      set           = ($urandom_range(0, 3) == 0);
      code          = 2'd0;
      mode          = 1'($urandom);
      core_done     = 1'($urandom);
      core_nerr     = 4'($urandom);
      core_err_vld  = 1'($urandom);
      core_err_loc  = 10'($urandom);
      core_err_last = 1'($urandom);
      idata         = {$urandom, $urandom};
      tick();
    end
    set = 1'b0; core_done = 1'b0; core_err_vld = 1'b0; core_err_last = 1'b0;
  endtask

  // One frame. nerr<0: core never completes (watchdog). rst_wr>0: reset after that many writes.
  task automatic frame(input bit m, input logic [1:0] c, input int nerr, input int dly,
                       input int rst_wr, input bit inc_words);
    int s, w, d, f, p, r, stop, bk;
    int bc[16];
    logic [DATA_W-1:0] words[128];
    s = cyc;
    w = wcnt(m, c);
    for (int i = 0; i < w; i++) words[i] = inc_words ? 64'(i) : {$urandom, $urandom};
    for (int k = 1; k <= w; k++) e_rdy[s + k] = 1'b1;
    for (int i = 0; i < w; i++) begin
      e_wr[s + 2 + i]   = 1'b1;
      e_addr[s + 2 + i] = ADDR_W'(i);
      e_wdat[s + 2 + i] = words[i];
    end
    e_st[s + w + 2] = 1'b1;
    e_cm[s + w + 2] = m;
    e_cc[s + w + 2] = c;
    if (nerr < 0) begin
      d = -1;
      f = s + w + 2 + TMO;
      e_fin[f] = 1'b1;
      e_od[f]  = 10'd1023;
    end else begin
      d = s + w + 2 + dly;
      if (nerr == 0) begin
        f = d + 1;
        e_fin[f] = 1'b1;
        e_od[f]  = 10'd1023;
      end else begin
        p = d + 1;
        for (int k = 0; k < nerr; k++) begin
          p += $urandom_range(0, 2);
          bc[k] = p;
          e_fin[p + 1] = 1'b1;
          e_od[p + 1]  = 10'(locs_q[k]);
          p++;
        end
        for (int t = d + 1; t <= bc[nerr - 1]; t++) e_err_rdy[t] = 1'b1;
        f = bc[nerr - 1] + 1;
      end
    end
    r = (rst_wr > 0) ? s + 1 + rst_wr : -1;
    if (r >= 0) begin
      for (int t = r + 1; t <= f + 2 && t < MAXC; t++) begin
        e_rdy[t] = 1'b0; e_wr[t] = 1'b0; e_st[t] = 1'b0; e_fin[t] = 1'b0; e_err_rdy[t] = 1'b0;
      end
    end
    stop = (r >= 0) ? r : f;

    set = 1'b1; mode = m; code = c;
    core_done = 1'b0; core_err_vld = 1'b0;
    tick();
    while (cyc <= stop) begin
      set   = (cyc == s + 5) || ($urandom_range(0, 5) == 0);
      code  = (cyc == s + 5) ? 2'd1 : 2'($urandom);
      mode  = 1'($urandom);
      idata = (cyc >= s + 2 && cyc < s + 2 + w) ? words[cyc - s - 2] : {$urandom, $urandom};
      core_done = (cyc == d);
      core_nerr = (cyc == d) ? 4'(nerr) : 4'($urandom);
      bk = -1;
      for (int k = 0; k < nerr; k++) if (bc[k] == cyc) bk = k;
      if (bk >= 0) begin
        core_err_vld  = 1'b1;
        core_err_loc  = 10'(locs_q[bk]);
        core_err_last = (bk == nerr - 1);
      end else if (d < 0 || cyc > d) begin
        core_err_vld  = 1'b0;
        core_err_loc  = 10'($urandom);
        core_err_last = 1'($urandom);
      end else begin
        core_err_vld  = 1'($urandom);
        core_err_loc  = 10'($urandom);
        core_err_last = 1'($urandom);
      end
      if (cyc == r) begin
        rstn = 1'b0;
        set  = 1'b0;
      end
      tick();
    end
    rstn = 1'b1; set = 1'b0; core_done = 1'b0; core_err_vld = 1'b0; core_err_last = 1'b0;
  endtask

  initial begin
    int nr;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_odata", 64'(odata), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_core_code", 64'(core_code), 64'd0);
    rstn = 1'b1;
    idle(3);

    // Hard n63, two locations.
    clr_mon();
    locs_q = '{5, 40};
    frame(1'b0, 2'd1, 2, 2, 0, 1'b0);
    chk("A_ready_cycles", 64'(n_ready_seen), 64'd1);
    chk("A_starts", 64'(n_start_seen), 64'd1);
    chk("A_writes", 64'(wa_seen.size()), 64'd1);
    chk("A_finish_beats", 64'(fin_seen.size()), 64'd2);
    if (fin_seen.size() == 2) begin
      chk("A_loc0", 64'(fin_seen[0]), 64'd5);
      chk("A_loc1", 64'(fin_seen[1]), 64'd40);
    end
    idle(2);

    // Soft n1023, incrementing words.
    clr_mon();
    locs_q = '{700};
    frame(1'b1, 2'd3, 1, 0, 0, 1'b1);
    chk("B_ready_cycles", 64'(n_ready_seen), 64'd128);
    chk("B_starts", 64'(n_start_seen), 64'd1);
    chk("B_writes", 64'(wa_seen.size()), 64'd128);
    if (wa_seen.size() == 128) chk("B_last_addr", 64'(wa_seen[127]), 64'd127);
    idle(2);

    // Zero errors, hard n255.
    clr_mon();
    frame(1'b0, 2'd2, 0, 3, 0, 1'b0);
    chk("C_ready_cycles", 64'(n_ready_seen), 64'd4);
    chk("C_finish_beats", 64'(fin_seen.size()), 64'd1);
    if (fin_seen.size() == 1) chk("C_sentinel", 64'(fin_seen[0]), 64'd1023);
    idle(2);

    // Hard n1023 with a set pulse mid-LOAD.
    clr_mon();
    locs_q = '{1, 2, 3};
    frame(1'b0, 2'd3, 3, 1, 0, 1'b0);
    chk("D_ready_cycles", 64'(n_ready_seen), 64'd16);
    chk("D_starts", 64'(n_start_seen), 64'd1);
    idle(2);

    // Reset after three of sixteen writes, then a fresh frame.
    clr_mon();
    frame(1'b0, 2'd3, 0, 0, 3, 1'b0);
    chk("E_ready_cycles", 64'(n_ready_seen), 64'd4);
    chk("E_writes", 64'(wa_seen.size()), 64'd3);
    chk("E_starts", 64'(n_start_seen), 64'd0);
    chk("E_post_ready", 64'(ready), 64'd0);
    chk("E_post_wr_en", 64'(wr_en), 64'd0);
    chk("E_post_finish", 64'(finish), 64'd0);
    idle(3);
    clr_mon();
    frame(1'b0, 2'd3, 0, 0, 0, 1'b0);
    if (wa_seen.size() > 0) chk("E_restart_addr", 64'(wa_seen[0]), 64'd0);
    chk("E_restart_writes", 64'(wa_seen.size()), 64'd16);
    idle(2);

`ifdef BCH_CTRL_TIMEOUT_EN
    clr_mon();
    frame(1'b0, 2'd1, -1, 0, 0, 1'b0);
    chk("T_finish_beats", 64'(fin_seen.size()), 64'd1);
    if (fin_seen.size() == 1) chk("T_sentinel", 64'(fin_seen[0]), 64'd1023);
    idle(2);
`endif

    // Randomized frames.
    for (int n = 0; n < 12; n++) begin
      nr = $urandom_range(0, 15);
      locs_q.delete();
      for (int k = 0; k < nr; k++) locs_q.push_back($urandom_range(0, 1022));
      frame(1'($urandom), 2'($urandom_range(1, 3)), nr, $urandom_range(0, 4), 0, 1'b0);
      idle($urandom_range(0, 3));
    end

    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bch_frame_ctrl.md
Name: bch_frame_ctrl

Overview:
- Front-end sequencer for the multi-length BCH decoder core; owns the host handshake (set/ready/finish/odata).
- On set, latches mode/code and requests the right number of 64-bit words from the host via ready.
- Writes those words into the core input buffer, starts the core, and waits for completion.
- Streams the core's error locations back to the host, one per finish beat.

Parameters:
- DATA_W, 64, host word width.
- LOC_W, 10, error-location width.
- ADDR_W, 7, core buffer word address width (max 128 words).
- TIMEOUT_CYC, 8192, watchdog limit in cycles (only used with the optional feature).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is synchronous and active-low.
- set  in  1  start pulse, 1 cycle.
- mode  in  1  0 = hard-decision, 1 = soft-decision.
- code  in  2  1 = n63, 2 = n255, 3 = n1023; 0 reserved.
- idata  in  DATA_W  host word.
- ready  out  1  word request to host.
- finish  out  1  odata valid.
- odata  out  LOC_W  error location, or sentinel 1023.
- core_start  out  1  1-cycle decode start.
- core_mode  out  1  latched mode.
- core_code  out  2  latched code.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer word address.
- wr_data  out  DATA_W  buffer word.
- core_done  in  1  decode complete, 1 cycle.
- core_nerr  in  4  number of located errors, valid with core_done.
- core_err_vld  in  1  location beat valid.
- core_err_loc  in  LOC_W  location.
- core_err_last  in  1  final beat.
- core_err_rdy  out  1  beat accept.

Behaviour:
- Reset (rstn=0 at posedge): state IDLE; all outputs 0; counters 0. Takes effect from any state, including mid-LOAD or mid-OUT. A core already running is not aborted by this block; its later core_done is ignored while IDLE.
- Word count W, selected by {mode, code}:
  - hard: code 1/2/3 → 1/4/16 words.
  - soft (8-bit LLR, 8 per word): code 1/2/3 → 8/32/128 words.
- IDLE:
  - set=1 with code≠0 → latch mode/code, clear counters, go LOAD.
  - set=1 with code=0 → ignored.
- LOAD:
  - ready=1 for exactly W consecutive cycles, starting the cycle after set is sampled.
  - Host presents word i during the cycle after the i-th ready-high cycle. The block samples idata one cycle after each ready-high cycle (1-cycle capture pipeline).
  - Each sample produces wr_en=1, wr_addr=i, wr_data=idata in the same cycle, i = 0..W-1.
  - After the write of word W-1: core_start=1 for the next cycle, go RUN.
  - ready and wr_en overlap for W-1 cycles.
- RUN:
  - Wait for core_done.
  - core_nerr=0 → go EMPTY.
  - core_nerr>0 → go OUT.
- EMPTY: one cycle with finish=1, odata=1023 (sentinel: no valid location equals 1023); then IDLE.
- OUT:
  - core_err_rdy=1.
  - Each accepted beat (vld&rdy) registers odata=core_err_loc, finish=1 the following cycle.
  - Gaps in core_err_vld give finish=0 cycles (odata holds).
  - Beat with core_err_last → after its finish cycle, go IDLE.
- finish is 0 in all other cycles. odata holds its last value while finish=0.
- set while not IDLE: ignored. No queueing.
- wr_addr never exceeds W-1. Counters do not wrap within a frame.
- Latency: set-sample → first ready = 1 cycle; last write → core_start = 1 cycle; accepted beat → finish = 1 cycle.

Optional Feature:
- BCH_CTRL_TIMEOUT_EN defined:
  - A cycle counter runs in RUN and OUT.
  - Reaching TIMEOUT_CYC without core_done (RUN) or core_err_last (OUT) forces core_err_rdy=0.
  - The block then emits one finish beat with odata=1023 and returns to IDLE.
  - The counter clears on entry to RUN.
- BCH_CTRL_TIMEOUT_EN undefined: no counter; RUN and OUT wait indefinitely.

Test Plan:
- Hard n63: set with mode=0, code=1; core returns nerr=2, locs 5 then 40 (last) → ready high 1 cycle; wr_addr 0; core_start 1 cycle later; finish beats odata=5 then 40; IDLE.
- Soft n1023: mode=1, code=3; drive incrementing words → exactly 128 ready cycles; wr_addr 0..127 with matching wr_data; one core_start pulse.
- Zero errors: code=2, hard; core_done with nerr=0 → 4 ready cycles; single finish beat odata=1023.
- Busy set: pulse set again mid-LOAD with code=1 → ignored; the original W=16 (hard, code=3) frame completes unchanged.
- Reset mid-LOAD: rstn=0 after 3 of 16 writes → next cycle ready=0, wr_en=0, finish=0. A new set then restarts at wr_addr 0.
- Timeout (macro on, TIMEOUT_CYC=100): never assert core_done → after 100 RUN cycles, one finish beat odata=1023, then IDLE.
